mem_main_memory_responder: RTL and testbench

- Memory-side endpoint of the core memory request/response protocol.
- Accepts core requests (read/write of one line) and returns in-order responses after a fixed pipelined latency.
- Holds a line-organised backing store.
- Sits behind the core bus delay line. It takes the place of the external memory model so the full core-to-memory path can be simulated end to end.

---
 rtl/mem_main_memory_responder.sv | 156 +++++++++++++++
 tb/tb_mem_main_memory_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_main_memory_responder.sv
// Memory-side responder: line-organised backing store, fixed-latency request
// pipeline and an in-order response FIFO guarded by an outstanding-credit counter.
module mem_main_memory_responder #(
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int MEM_LINES       = 1024,
    parameter int TAG_WIDTH       = 4,
    parameter int MEM_LATENCY     = 5,
    parameter int RESP_FIFO_DEPTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_write,
    output logic [ADDR_WIDTH-1:0] resp_addr,
    output logic [LINE_WIDTH-1:0] resp_data,
    output logic [TAG_WIDTH-1:0]  resp_tag
);

    localparam int OFS   = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int PTR_W = (RESP_FIFO_DEPTH > 1) ? $clog2(RESP_FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_FIFO_DEPTH + 1);
    localparam int LAST  = MEM_LATENCY - 1;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic [IDX_W-1:0]      w_idx;
    logic [LINE_WIDTH-1:0] w_s0_data;

    logic [LINE_WIDTH-1:0] r_mem [MEM_LINES];
    logic [LINE_WIDTH-1:0] r_rd_data;

    logic                  r_pv [MEM_LATENCY];
    logic                  r_pw [MEM_LATENCY];
    logic [ADDR_WIDTH-1:0] r_pa [MEM_LATENCY];
    logic [LINE_WIDTH-1:0] r_pd [MEM_LATENCY];
    logic [TAG_WIDTH-1:0]  r_pt [MEM_LATENCY];
    logic [LINE_WIDTH-1:0] w_sd [MEM_LATENCY];

    logic                  r_fw [RESP_FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fa [RESP_FIFO_DEPTH];
    logic [LINE_WIDTH-1:0] r_fd [RESP_FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  r_ft [RESP_FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_fifo_count;
    logic [CNT_W-1:0]      r_outstanding;

    function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_ready = reset && (r_outstanding < CNT_W'(RESP_FIFO_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_idx     = req_addr[OFS +: IDX_W];
    assign w_pop     = resp_valid && resp_ready;
    assign w_push    = r_pv[LAST];

    // Store is never reset; read is registered on the accept edge into stage 0.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            if (req_write) begin
                r_mem[w_idx] <= req_data;
            end
            r_rd_data <= r_mem[w_idx];
        end
    end

    // Stage 0 data field carries the write data; reads substitute the RAM output.
    assign w_s0_data = r_pw[0] ? r_pd[0] : r_rd_data;

    for (genvar gi = 0; gi < MEM_LATENCY; gi++) begin : g_stage_data
        if (gi == 0) begin : g_first
            assign w_sd[gi] = w_s0_data;
        end else begin : g_rest
            assign w_sd[gi] = r_pd[gi];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pw[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pd[i] <= '0;
                r_pt[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_accept;
            r_pw[0] <= req_write;
            r_pa[0] <= req_addr;
            r_pd[0] <= req_data;
            r_pt[0] <= req_tag;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pw[i] <= r_pw[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pd[i] <= w_sd[i-1];
                r_pt[i] <= r_pt[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fw[r_wr_ptr] <= r_pw[LAST];
            r_fa[r_wr_ptr] <= r_pa[LAST];
            r_fd[r_wr_ptr] <= w_sd[LAST];
            r_ft[r_wr_ptr] <= r_pt[LAST];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_count  <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 1'b1;
                2'b01:   r_fifo_count <= r_fifo_count - 1'b1;
                default: r_fifo_count <= r_fifo_count;
            endcase
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Head is gated so the response bus reads zero whenever nothing is presented.
    assign resp_valid = (r_fifo_count != '0);
    assign resp_write = resp_valid ? r_fw[r_rd_ptr] : 1'b0;
    assign resp_addr  = resp_valid ? r_fa[r_rd_ptr] : '0;
    assign resp_data  = resp_valid ? r_fd[r_rd_ptr] : '0;
    assign resp_tag   = resp_valid ? r_ft[r_rd_ptr] : '0;

endmodule

// File: tb/tb_mem_main_memory_responder.sv
// Randomised and directed bench for mem_main_memory_responder against a
// transaction-level model: a line array plus a queue of timestamped responses.
module tb_mem_main_memory_responder;

    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int ML    = 1024;
    localparam int TW    = 4;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int OFS   = $clog2(LW / 8);
    localparam int IW    = $clog2(ML);

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_data = '0;
    logic [TW-1:0] req_tag = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          resp_write;
    logic [AW-1:0] resp_addr;
    logic [LW-1:0] resp_data;
    logic [TW-1:0] resp_tag;

    mem_main_memory_responder #(
        .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .MEM_LINES(ML), .TAG_WIDTH(TW),
        .MEM_LATENCY(LAT), .RESP_FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_addr(resp_addr), .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            acc;
        logic          w;
        logic [AW-1:0] a;
        logic [LW-1:0] d;
        logic [TW-1:0] t;
    } rsp_t;

    rsp_t          q[$];
    logic [LW-1:0] mmem [ML];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            last_acc = 0;

    function automatic bit m_ready();
        return reset && (q.size() < DEPTH);
    endfunction

    function automatic bit m_rvalid();
        return (q.size() > 0) && (cyc >= q[0].acc + LAT);
    endfunction

    task automatic expect_eq(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: decide the handshakes from the model, then advance it on the edge.
    task automatic tick();
        bit   acc;
        bit   pop;
        rsp_t e;
        acc = req_valid && m_ready();
        pop = m_rvalid() && resp_ready;
        e = '{0, 1'b0, '0, '0, '0};
        if (acc) begin
            e.acc = cyc + 1;
            e.w   = req_write;
            e.a   = req_addr;
            e.d   = req_write ? req_data : mmem[req_addr[OFS +: IW]];
            e.t   = req_tag;
        end
        @(posedge clock);
        cyc++;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (e.w) mmem[e.a[OFS +: IW]] = e.d;
        end
        last_acc = acc;
        @(negedge clock);
    endtask

    task automatic send(input bit w, input logic [AW-1:0] a, input logic [LW-1:0] d, input logic [TW-1:0] t);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_tag   = t;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (last_acc) break;
        end
        req_valid = 1'b0;
        expect_eq("send_accepted", last_acc, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic await_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
        expect_eq("await_resp_timeout", resp_valid, 1'b1);
    endtask

    // Compare process: every cycle, 2 time units after the active edge.
    initial begin
        forever begin
            @(posedge clock);
            #2;
            expect_eq("req_ready", req_ready, m_ready());
            expect_eq("resp_valid", resp_valid, m_rvalid());
            if (m_rvalid()) begin
                expect_eq("resp_write", resp_write, q[0].w);
                expect_eq("resp_addr", resp_addr, q[0].a);
                expect_eq("resp_data", resp_data, q[0].d);
                expect_eq("resp_tag", resp_tag, q[0].t);
            end else if (!reset) begin
                expect_eq("rst_resp_write", resp_write, 1'b0);
                expect_eq("rst_resp_addr", resp_addr, '0);
                expect_eq("rst_resp_data", resp_data, '0);
                expect_eq("rst_resp_tag", resp_tag, '0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            lat;
        int            got;
        int            first;
        int            n_acc;
        logic [LW-1:0] pat_a;
        logic [LW-1:0] pat_d;
        logic [AW-1:0] ra;
        pat_a = {8{16'hAAAA}};
        pat_d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        #1 reset = 1'b0;
        q.delete();
        @(negedge clock);
        idle(2);
        expect_eq("reset_req_ready", req_ready, 1'b0);
        expect_eq("reset_resp_valid", resp_valid, 1'b0);
        reset = 1'b1;
        #1 expect_eq("release_req_ready", req_ready, 1'b1);
        @(negedge clock);

        // Read latency and data of a freshly written line.
        resp_ready = 1'b1;
        send(1'b1, 32'h40, pat_a, 4'd1);
        idle(8);
        send(1'b0, 32'h40, '0, 4'd3);
        await_resp(lat);
        expect_eq("read_latency", lat, LAT);
        expect_eq("read_data", resp_data, pat_a);
        expect_eq("read_tag", resp_tag, 4'd3);
        expect_eq("read_write_flag", resp_write, 1'b0);
        idle(3);

        // Back-to-back ordering.
        for (int i = 0; i < 4; i++) send(1'b1, AW'(i * 16), LW'(i), 4'(i));
        idle(8);
        for (int i = 0; i < 4; i++) send(1'b0, AW'(i * 16), '0, 4'(i));
        got = 0;
        first = -1;
        for (int i = 0; i < 20; i++) begin
            if (resp_valid && got < 4) begin
                if (first < 0) first = i;
                expect_eq("b2b_data", resp_data, LW'(got));
                expect_eq("b2b_tag", resp_tag, TW'(got));
                expect_eq("b2b_consecutive", i, first + got);
                got++;
            end
            tick();
        end
        expect_eq("b2b_count", got, 4);

        // Backpressure: only DEPTH reads are taken while nothing drains.
        resp_ready = 1'b0;
        n_acc = 0;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int i = 0; i < 10; i++) begin
            req_addr = AW'((i % 4) * 16);
            req_tag  = TW'(n_acc);
            tick();
            if (last_acc) n_acc++;
        end
        expect_eq("bp_accepted", n_acc, DEPTH);
        expect_eq("bp_ready_low", req_ready, 1'b0);
        idle(3);
        expect_eq("bp_hold_tag", resp_tag, 4'd0);
        expect_eq("bp_hold_data", resp_data, '0);
        resp_ready = 1'b1;
        expect_eq("full_pop_ready_low", req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        expect_eq("ready_after_first_pop", req_ready, 1'b1);
        got = 1;
        for (int i = 0; i < 20 && got < DEPTH; i++) begin
            if (resp_valid) begin
                expect_eq("drain_tag", resp_tag, TW'(got));
                expect_eq("drain_data", resp_data, LW'(got % 4));
                got++;
            end
            tick();
        end
        expect_eq("drain_count", got, DEPTH);
        idle(2);

        // Steady state at seven outstanding with an accept and a pop every cycle.
        resp_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(1'b0, AW'((i % 4) * 16), '0, 4'(i));
        idle(LAT + 1);
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            req_tag = TW'(i);
            expect_eq("steady_ready", req_ready, 1'b1);
            expect_eq("steady_valid", resp_valid, 1'b1);
            tick();
            expect_eq("steady_outstanding", q.size(), 7);
        end
        req_valid = 1'b0;
        idle(16);

        // Aliasing across the top of the store.
        send(1'b1, 32'h0, pat_d, 4'd5);
        idle(8);
        send(1'b0, AW'(ML * 16), '0, 4'd6);
        await_resp(lat);
        expect_eq("alias_data", resp_data, pat_d);
        idle(3);

        // Reset with responses both queued and in flight.
        resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(1'b0, 32'h40, '0, 4'(i));
        idle(2);
        expect_eq("pre_reset_valid", resp_valid, 1'b1);
        reset = 1'b0;
        q.delete();
        #1 expect_eq("reset_async_valid", resp_valid, 1'b0);
        expect_eq("reset_async_ready", req_ready, 1'b0);
        expect_eq("reset_async_data", resp_data, '0);
        @(negedge clock);
        idle(2);
        reset = 1'b1;
        resp_ready = 1'b1;
        idle(12);
        send(1'b0, 32'h40, '0, 4'd9);
        await_resp(lat);
        expect_eq("post_reset_data", resp_data, pat_a);
        idle(3);

        // Randomised traffic over 16 lines reached through aliased addresses.
        for (int i = 0; i < 16; i++) send(1'b1, AW'(i * 16), {4{$urandom}}, 4'(i));
        for (int i = 0; i < 800; i++) begin
            ra = $urandom;
            ra[OFS +: IW] = IW'($urandom_range(0, 15));
            req_valid  = ($urandom_range(0, 9) < 7);
            req_write  = ($urandom_range(0, 9) < 4);
            req_addr   = ra;
            req_data   = {$urandom, $urandom, $urandom, $urandom};
            req_tag    = TW'($urandom);
            resp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        idle(DEPTH + LAT + 4);
        expect_eq("final_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
